// File: rtl/ifm_window_streamer.sv
// ifm_window_streamer: streams one IFM from RAM in raster order into the window line-buffer FIFO.
// Latency: read issued in cycle t is pushed in cycle t+1; window_valid follows that push by one cycle.
// Backpressure: stall blocks new reads (address holds); a read already in flight is always pushed.
//
// Ports:
//   clk, reset (sync, active-high), start (one-cycle request), stall (downstream not ready)
//   ram_rd_en / ram_addr / ram_data_in : IFM RAM read port (data one cycle after strobe)
//   fifo_enable / fifo_data_in         : pixel push into the window FIFO
//   window_valid, busy, done           : stream status
//   window_idx (only with `define WINDOW_INDEX_EN) : zero-based index of the current window
module ifm_window_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 9,
  parameter int KERNAL_SIZE = 5,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  fifo_enable,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  window_valid,
  output logic                  busy,
`ifdef WINDOW_INDEX_EN
  output logic                  done,
  output logic [9:0]            window_idx
`else
  output logic                  done
`endif
);

  localparam int CW = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IFM_SIZE * IFM_SIZE - 1);
  localparam logic [CW-1:0] EDGE_MAX = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] WIN_MIN  = CW'(KERNAL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    fifo_en_q;
  logic [CW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic                    win_vld_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    rd_en_d;

  // Read strobe follows stall combinationally so a stalled cycle issues no read.
  // Gating by reset keeps the aborted cycle from issuing a read at all.
  assign rd_en_d = (state_q == FETCH) && !stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      fifo_en_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      win_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fifo_en_q <= rd_en_d;
      done_q    <= 1'b0;
      // Counters describe the pixel being pushed this cycle.
      win_vld_q <= fifo_en_q && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
      if (fifo_en_q) begin
        if (col_q == EDGE_MAX) begin
          col_q <= '0;
          row_q <= (row_q == EDGE_MAX) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        FETCH: begin
          if (rd_en_d) begin
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The final read is always pushed the cycle after it issues.
          if (fifo_en_q) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_rd_en    = rd_en_d;
  assign ram_addr     = addr_q;
  assign fifo_enable  = fifo_en_q;
  assign fifo_data_in = fifo_en_q ? ram_data_in : '0;
  assign window_valid = win_vld_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef WINDOW_INDEX_EN
  logic [9:0] win_idx_q;

  // Advances after each window so it reads the current index while window_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_idx_q <= '0;
    end else if (state_q == IDLE && start) begin
      win_idx_q <= '0;
    end else if (win_vld_q) begin
      win_idx_q <= win_idx_q + 1'b1;
    end
  end

  assign window_idx = win_idx_q;
`endif

endmodule

// File: tb/tb_ifm_window_streamer.sv
module tb_ifm_window_streamer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        ram_rd_en;
  logic [6:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic        fifo_enable;
  logic [31:0] fifo_data_in;
  logic        window_valid;
  logic        busy;
  logic        done;
`ifdef WINDOW_INDEX_EN
  logic [9:0]  window_idx;
`endif

  ifm_window_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .ram_rd_en    (ram_rd_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .fifo_enable  (fifo_enable),
    .fifo_data_in (fifo_data_in),
    .window_valid (window_valid),
    .busy         (busy),
`ifdef WINDOW_INDEX_EN
    .done         (done),
    .window_idx   (window_idx)
`else
    .done         (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word = mem_base + address, one cycle read latency.
  int mem_base;
  always @(posedge clk) begin
    if (ram_rd_en) ram_data_in <= 32'(mem_base) + 32'(ram_addr);
    else           ram_data_in <= 32'hDEADBEEF;
  end

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-run observations.
  int q_pix[$];
  int q_win[$];
  int cnt_rd, first_rd, last_rd, rd_in_stall;
  int cnt_fe, first_fe, last_fe, fe10, fe31, idle_nz;
  int cnt_busy, first_busy, last_busy;
  int cnt_win, first_win, last_win;
  int cnt_done, done_cyc;
  int dat42;
  logic [63:0] outs31;
  int idx_first, idx47, idx83;

  task automatic run(input int slo, input int shi, input int rs, input int rc,
                     input int n, input int b);
    int exp_addr;
    logic prev_fe;
    int prev_dat;
    mem_base = b;
    q_pix.delete();
    q_win.delete();
    for (int a = 0; a < 81; a++) q_pix.push_back(b + a);
    for (int r = 4; r < 9; r++)
      for (int c = 4; c < 9; c++) q_win.push_back(b + r * 9 + c);
    cnt_rd = 0; first_rd = -1; last_rd = -1; rd_in_stall = 0;
    cnt_fe = 0; first_fe = -1; last_fe = -1; fe10 = 0; fe31 = 1; idle_nz = 0;
    cnt_busy = 0; first_busy = -1; last_busy = -1;
    cnt_win = 0; first_win = -1; last_win = -1;
    cnt_done = 0; done_cyc = -1; dat42 = -1; outs31 = '1;
    idx_first = -1; idx47 = -1; idx83 = -1;
    exp_addr = 0; prev_fe = 1'b0; prev_dat = 0;
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (c == rs);
      stall = (c >= slo) && (c <= shi);
      reset = (c == rc);
      @(negedge clk);
      if (ram_rd_en) begin
        cnt_rd++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        if (c >= slo && c <= shi) rd_in_stall++;
        check("rd_addr", 64'(ram_addr), 64'(exp_addr));
        exp_addr++;
      end
      if (fifo_enable) begin
        cnt_fe++;
        if (first_fe < 0) first_fe = c;
        last_fe = c;
        if (q_pix.size() > 0) check("push_dat", 64'(fifo_data_in), 64'(q_pix.pop_front()));
      end else if (fifo_data_in != 0) begin
        idle_nz++;
      end
      if (c == 10) fe10 = int'(fifo_enable);
      if (c == 31) fe31 = int'(fifo_enable);
      if (c == 42) dat42 = int'(fifo_data_in);
      if (c == 31) outs31 = 64'({ram_rd_en, ram_addr, fifo_enable, fifo_data_in,
                                 window_valid, busy, done});
      if (busy) begin
        cnt_busy++;
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
      if (window_valid) begin
        cnt_win++;
        if (first_win < 0) first_win = c;
        last_win = c;
        check("win_after_push", 64'(prev_fe), 64'd1);
        if (q_win.size() > 0) check("win_pix", 64'(prev_dat), 64'(q_win.pop_front()));
`ifdef WINDOW_INDEX_EN
        if (cnt_win == 1) idx_first = int'(window_idx);
        if (c == 47) idx47 = int'(window_idx);
        if (c == 83) idx83 = int'(window_idx);
`endif
      end
      if (done) begin
        cnt_done++;
        done_cyc = c;
        check("busy_at_done", 64'(busy), 64'd0);
      end
      prev_fe = fifo_enable;
      prev_dat = int'(fifo_data_in);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
  endtask

  task automatic check_nominal();
    check("rd_count", 64'(cnt_rd), 64'd81);
    check("rd_first", 64'(first_rd), 64'd1);
    check("rd_last", 64'(last_rd), 64'd81);
    check("fe_first", 64'(first_fe), 64'd2);
    check("fe_last", 64'(last_fe), 64'd82);
    check("fe_count", 64'(cnt_fe), 64'd81);
    check("idle_dat_zero", 64'(idle_nz), 64'd0);
    check("busy_first", 64'(first_busy), 64'd1);
    check("busy_last", 64'(last_busy), 64'd82);
    check("busy_count", 64'(cnt_busy), 64'd82);
    check("done_count", 64'(cnt_done), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'd83);
    check("win_first", 64'(first_win), 64'd43);
    check("win_last", 64'(last_win), 64'd83);
    check("win_count", 64'(cnt_win), 64'd25);
    check("dat_c42", 64'(dat42), 64'(mem_base + 40));
`ifdef WINDOW_INDEX_EN
    check("idx_first", 64'(idx_first), 64'd0);
    check("idx_c47", 64'(idx47), 64'd4);
    check("idx_c83", 64'(idx83), 64'd24);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    mem_base = 0;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", 64'({ram_rd_en, ram_addr, fifo_enable, fifo_data_in,
                              window_valid, busy, done}), 64'd0);
    @(posedge clk);
    #1;

    // Nominal stream, RAM word = address.
    run(-1, -1, -1, -1, 90, 0);
    check_nominal();

    // Stall for cycles 10..14.
    run(10, 14, -1, -1, 95, 100);
    check("stall_no_reads", 64'(rd_in_stall), 64'd0);
    check("stall_push_c10", 64'(fe10), 64'd1);
    check("stall_rd_count", 64'(cnt_rd), 64'd81);
    check("stall_rd_last", 64'(last_rd), 64'd86);
    check("stall_done_cycle", 64'(done_cyc), 64'd88);
    check("stall_done_count", 64'(cnt_done), 64'd1);
    check("stall_win_count", 64'(cnt_win), 64'd25);

    // Second start mid-stream is ignored.
    run(-1, -1, 20, -1, 90, 200);
    check("restart_done_cycle", 64'(done_cyc), 64'd83);
    check("restart_done_count", 64'(cnt_done), 64'd1);
    check("restart_rd_count", 64'(cnt_rd), 64'd81);

    // Reset mid-stream at cycle 30.
    run(-1, -1, -1, 30, 40, 300);
    check("rst_outputs_c31", outs31, 64'd0);
    check("rst_no_push_c31", 64'(fe31), 64'd0);
    check("rst_no_done", 64'(cnt_done), 64'd0);

    // Fresh stream after the abort must start again at address 0.
    run(-1, -1, -1, -1, 90, 400);
    check_nominal();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
